// File: rtl/zrb_spi_fifo_master.sv
// zrb_spi_fifo_master
//   SPI mode-0 byte engine between a show-ahead TX FIFO and an RX FIFO.
//   Pops a byte from the TX FIFO, shifts it out MSB-first on mosi while
//   capturing miso on each rising sclk edge, then pushes the received byte
//   into the RX FIFO. cs_n stays low across back-to-back bytes, and the
//   engine stalls with the bus frozen while the RX FIFO is full.
//
// Parameters
//   DATA_WIDTH  bits per transfer (also the FIFO data width), >= 2
//   CLK_DIV     sclk half-period in clk cycles (1..65535)
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   enable              level; engine drains the TX FIFO while high
//   tx_data, tx_empty   TX FIFO head (valid when not empty) and empty flag
//   tx_rd_en            one-cycle pop pulse to the TX FIFO
//   rx_data, rx_wr_en   received byte and one-cycle push pulse to the RX FIFO
//   rx_full             RX FIFO full flag
//   sclk, mosi, miso    SPI clock (idle low), data out, data in
//   cs_n                chip select, active low
//   busy                high whenever the engine is not idle
module zrb_spi_fifo_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_empty,
    output logic                  tx_rd_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_wr_en,
    input  logic                  rx_full,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n,
    output logic                  busy
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
    logic [DATA_WIDTH-1:0] rx_data_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [15:0]           div_cnt, div_cnt_n;
    logic                  sclk_n, mosi_n, cs_n_n, busy_n;
    logic                  tx_rd_en_n, rx_wr_en_n;
    logic                  start;
    logic                  load;

    // A byte is available and the engine is allowed to take it.
    assign start = enable && !tx_empty;

    always_comb begin
        // NOTE: every next-value defaults to its current value (pulses to 0)
        // before the case, so no path through it can infer a latch.
        state_n    = state;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        bit_cnt_n  = bit_cnt;
        div_cnt_n  = div_cnt;
        sclk_n     = sclk;
        mosi_n     = mosi;
        cs_n_n     = cs_n;
        tx_rd_en_n = 1'b0;
        rx_wr_en_n = 1'b0;
        load       = 1'b0;

        case (state)
            IDLE: load = start;
            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    // Rising sclk edge: the slave's bit is sampled here.
                    sclk_n     = 1'b1;
                    rx_shift_n = {rx_shift[DATA_WIDTH-2:0], miso};
                    div_cnt_n  = '0;
                    state_n    = HIGH;
                end else begin
                    div_cnt_n = div_cnt + 16'd1;
                end
            end
            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    sclk_n    = 1'b0;
                    div_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = DONE;
                    end else begin
                        // Falling sclk edge: present the next bit.
                        bit_cnt_n  = bit_cnt + CNT_W'(1);
                        tx_shift_n = tx_shift << 1;
                        mosi_n     = tx_shift[DATA_WIDTH-2];
                        state_n    = LOW;
                    end
                end else begin
                    div_cnt_n = div_cnt + 16'd1;
                end
            end
            DONE: begin
                // While the RX FIFO is full everything holds its value.
                if (!rx_full) begin
                    rx_data_n  = rx_shift;
                    rx_wr_en_n = 1'b1;
                    if (start) begin
                        load = 1'b1;
                    end else begin
                        cs_n_n  = 1'b1;
                        mosi_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Byte load, shared by IDLE and back-to-back continuation from DONE.
        // The pop happens in the same cycle the head byte is captured.
        if (load) begin
            tx_shift_n = tx_data;
            mosi_n     = tx_data[DATA_WIDTH-1];
            cs_n_n     = 1'b0;
            sclk_n     = 1'b0;
            tx_rd_en_n = 1'b1;
            bit_cnt_n  = '0;
            div_cnt_n  = '0;
            state_n    = LOW;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shift registers are ordinary flops rather than a
            // memory array, so they are cleared with everything else and
            // an aborted transfer leaves no stale partial byte behind.
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            tx_rd_en <= 1'b0;
            rx_wr_en <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the pre-edge values computed above.
            state    <= state_n;
            tx_shift <= tx_shift_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            bit_cnt  <= bit_cnt_n;
            div_cnt  <= div_cnt_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
            cs_n     <= cs_n_n;
            busy     <= busy_n;
            tx_rd_en <= tx_rd_en_n;
            rx_wr_en <= rx_wr_en_n;
        end
    end

endmodule

// File: tb/tb_zrb_spi_fifo_master.sv
// tb_zrb_spi_fifo_master
//   Self-checking bench for zrb_spi_fifo_master (DATA_WIDTH=8, CLK_DIV=2).
//   The TX FIFO is a queue in the bench; RX pushes are logged. Expected pin
//   values are derived from the byte timing rules: after a load (t=0),
//   sclk is high when (t/N) is odd for t < 16N, mosi carries bit 7-t/(2N),
//   miso is sampled at t = N + 2Nk, and the RX push lands at t = 16N+1.
module tb_zrb_spi_fifo_master;
    localparam int DW     = 8;
    localparam int N      = 2;
    localparam int HALF2  = 2 * N;
    localparam int BYTE_T = 2 * N * DW;

    logic          clk = 1'b0;
    logic          reset, enable, tx_empty, rx_full, miso;
    logic [DW-1:0] tx_data;
    logic          tx_rd_en, rx_wr_en, sclk, mosi, cs_n, busy;
    logic [DW-1:0] rx_data;

    int n_checks  = 0;
    int n_fail    = 0;
    int cycle     = 0;
    int n_pops    = 0;
    int miso_mode = 0;  // 0 loopback, 1 inverted loopback, 2 random

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_log[$];

    localparam logic [5:0] IDLE_PINS = 6'b011000;  // sclk,mosi,cs_n,busy,rd,wr

    always #5 clk = ~clk;

    zrb_spi_fifo_master #(.DATA_WIDTH(DW), .CLK_DIV(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tx_data  (tx_data),
        .tx_empty (tx_empty),
        .tx_rd_en (tx_rd_en),
        .rx_data  (rx_data),
        .rx_wr_en (rx_wr_en),
        .rx_full  (rx_full),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n),
        .busy     (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] pins();
        return {sclk, mosi, cs_n, busy, tx_rd_en, rx_wr_en};
    endfunction

    task automatic refresh_fifo();
        tx_empty = (tx_q.size() == 0);
        tx_data  = tx_empty ? '0 : tx_q[0];
    endtask

    task automatic push(input logic [DW-1:0] b);
        tx_q.push_back(b);
        refresh_fifo();
    endtask

    // One clock: FIFO side-effects of the edge, protocol rules, then new inputs.
    task automatic tick();
        logic was_empty, was_full;
        was_empty = tx_empty;
        was_full  = rx_full;
        @(posedge clk);
        #1;
        cycle++;
        if (tx_rd_en === 1'b1) begin
            n_pops++;
            n_checks++;
            if (was_empty) begin
                n_fail++;
                $display("FAIL pop_while_empty cycle=%0d tx_rd_en=1 required 0", cycle);
            end else begin
                void'(tx_q.pop_front());
            end
        end
        if (rx_wr_en === 1'b1) begin
            n_checks++;
            if (was_full) begin
                n_fail++;
                $display("FAIL push_while_full cycle=%0d rx_wr_en=1 required 0", cycle);
            end
            rx_log.push_back(rx_data);
        end
        case (miso_mode)
            0:       miso = mosi;
            1:       miso = ~mosi;
            default: miso = 1'($urandom_range(0, 1));
        endcase
        refresh_fifo();
    endtask

    task automatic wait_load(input string name, output bit ok);
        logic [DW-1:0] head;
        logic [5:0]    exp;
        ok   = 1'b0;
        head = '0;
        for (int i = 0; i < 8 && !ok; i++) begin
            head = (tx_q.size() != 0) ? tx_q[0] : '0;
            tick();
            if (tx_rd_en === 1'b1) ok = 1'b1;
        end
        exp = {1'b0, head[DW-1], 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_load tx_rd_en never seen within 8 cycles, required a pop", name);
        end else if (pins() !== exp) begin
            n_fail++;
            $display("FAIL %s_load pins=%b required %b", name, pins(), exp);
        end
    endtask

    // Follows one byte from the cycle after its load to its RX push.
    task automatic xfer(input string name, input logic [DW-1:0] b, input int drop_t,
                        input int stall, output bit more);
        logic [5:0]    exp;
        logic [DW-1:0] exp_rx, head;
        logic          exp_sclk;
        int            k;
        exp_rx = '0;
        if (stall > 0) rx_full = 1'b1;
        for (int t = 1; t <= BYTE_T; t++) begin
            if (t == drop_t) enable = 1'b0;
            if (t % HALF2 == N) exp_rx = {exp_rx[DW-2:0], miso};
            tick();
            k        = (t / HALF2 < DW) ? t / HALF2 : DW - 1;
            exp_sclk = (t < BYTE_T) && ((t / N) % 2 == 1);
            exp      = {exp_sclk, b[DW-1-k], 1'b0, 1'b1, 1'b0, 1'b0};
            n_checks++;
            if (pins() !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0d pins{sclk,mosi,cs_n,busy,rd,wr}=%b required %b",
                         name, t, pins(), exp);
            end
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            exp = {1'b0, b[0], 1'b0, 1'b1, 1'b0, 1'b0};
            n_checks++;
            if (pins() !== exp) begin
                n_fail++;
                $display("FAIL %s_stall s=%0d pins=%b required %b", name, s, pins(), exp);
            end
        end
        rx_full = 1'b0;
        more    = enable && (tx_q.size() != 0);
        head    = more ? tx_q[0] : '0;
        tick();
        exp = {1'b0, more ? head[DW-1] : 1'b1, ~more, more, more, 1'b1};
        n_checks++;
        if (pins() !== exp) begin
            n_fail++;
            $display("FAIL %s_push pins=%b required %b", name, pins(), exp);
        end
        n_checks++;
        if (rx_data !== exp_rx) begin
            n_fail++;
            $display("FAIL %s_rx_data got %h required %h", name, rx_data, exp_rx);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        rx_full   = 1'b0;
        miso      = 1'b0;
        miso_mode = 0;
        tx_q.delete();
        refresh_fifo();
        @(posedge clk);
        #1;
        n_checks++;
        if (pins() !== IDLE_PINS) begin
            n_fail++;
            $display("FAIL reset_pins got %b required %b", pins(), IDLE_PINS);
        end
        n_checks++;
        if (rx_data !== '0) begin
            n_fail++;
            $display("FAIL reset_rx_data got %h required 00", rx_data);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pins() !== IDLE_PINS) begin
                n_fail++;
                $display("FAIL post_reset_idle got %b required %b", pins(), IDLE_PINS);
            end
        end
    endtask

    task automatic test_single_byte();
        bit ok, more;
        int p0, r0;
        miso_mode = 0;
        enable    = 1'b1;
        p0        = n_pops;
        r0        = rx_log.size();
        push(8'hA5);
        wait_load("single", ok);
        if (ok) xfer("single", 8'hA5, 0, 0, more);
        n_checks++;
        if (rx_log.size() != r0 + 1 || rx_log[$] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_rx got %0d pushes last %h, required 1 push of a5",
                     rx_log.size() - r0, (rx_log.size() != 0) ? rx_log[$] : 8'h00);
        end
        n_checks++;
        if (n_pops - p0 != 1) begin
            n_fail++;
            $display("FAIL single_pops got %0d required 1", n_pops - p0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (pins() !== IDLE_PINS) begin
                n_fail++;
                $display("FAIL single_idle got %b required %b", pins(), IDLE_PINS);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] bytes [3];
        bit            ok, more;
        int            p0, r0;
        bytes     = '{8'h3C, 8'hFF, 8'h00};
        miso_mode = 0;
        enable    = 1'b1;
        p0        = n_pops;
        r0        = rx_log.size();
        foreach (bytes[i]) push(bytes[i]);
        wait_load("b2b", ok);
        more = ok;
        for (int i = 0; i < 3 && more; i++) xfer("b2b", bytes[i], 0, 0, more);
        n_checks++;
        if (rx_log.size() != r0 + 3) begin
            n_fail++;
            $display("FAIL b2b_rx_count got %0d required 3", rx_log.size() - r0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rx_log[r0+i] !== bytes[i]) begin
                    n_fail++;
                    $display("FAIL b2b_rx[%0d] got %h required %h", i, rx_log[r0+i], bytes[i]);
                end
            end
        end
        n_checks++;
        if (n_pops - p0 != 3) begin
            n_fail++;
            $display("FAIL b2b_pops got %0d required 3", n_pops - p0);
        end
    endtask

    task automatic test_rx_backpressure();
        bit ok, more;
        miso_mode = 0;
        enable    = 1'b1;
        push(8'h81);
        wait_load("bp", ok);
        if (ok) xfer("bp", 8'h81, 0, 20, more);
        n_checks++;
        if (rx_log.size() == 0 || rx_log[$] !== 8'h81) begin
            n_fail++;
            $display("FAIL bp_rx last push %h required 81", (rx_log.size() != 0) ? rx_log[$] : 8'h00);
        end
    endtask

    task automatic test_empty_idle();
        logic [5:0] exp;
        bit         more;
        miso_mode = 0;
        enable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (pins() !== IDLE_PINS) begin
                n_fail++;
                $display("FAIL empty_idle i=%0d got %b required %b", i, pins(), IDLE_PINS);
            end
        end
        push(8'h42);
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (pins() !== exp) begin
            n_fail++;
            $display("FAIL empty_late_start got %b required %b", pins(), exp);
        end else begin
            xfer("late", 8'h42, 0, 0, more);
        end
    endtask

    task automatic test_enable_drop();
        bit ok, more;
        int p0;
        miso_mode = 0;
        enable    = 1'b1;
        push(8'h5A);
        push(8'h11);
        wait_load("drop", ok);
        p0 = n_pops;
        if (ok) xfer("drop", 8'h5A, 3 * HALF2 + 1, 0, more);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (pins() !== IDLE_PINS) begin
                n_fail++;
                $display("FAIL drop_idle got %b required %b", pins(), IDLE_PINS);
            end
        end
        n_checks++;
        if (n_pops != p0 || tx_q.size() != 1 || tx_q[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL drop_queue pops=%0d depth=%0d, required 0 pops and 11 left",
                     n_pops - p0, tx_q.size());
        end
    endtask

    task automatic test_reset_mid_byte();
        bit ok, more;
        int r0;
        miso_mode = 0;
        push(8'hC3);
        enable = 1'b1;
        wait_load("rst_first", ok);
        r0 = rx_log.size();
        for (int t = 1; t <= 4 * HALF2 + N; t++) tick();  // bit 4, sclk high
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pins() !== IDLE_PINS) begin
            n_fail++;
            $display("FAIL mid_reset_pins got %b required %b", pins(), IDLE_PINS);
        end
        tick();
        #2 reset = 1'b0;
        n_checks++;
        if (rx_log.size() != r0) begin
            n_fail++;
            $display("FAIL mid_reset_push got %0d pushes required 0", rx_log.size() - r0);
        end
        wait_load("rst_restart", ok);
        if (ok) xfer("rst_restart", 8'hC3, 0, 0, more);
        n_checks++;
        if (rx_log.size() != r0 + 1 || rx_log[$] !== 8'hC3) begin
            n_fail++;
            $display("FAIL rst_restart_rx got %0d pushes, required 1 push of c3", rx_log.size() - r0);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] bytes [$];
        bit            ok, more;
        int            k, stall;
        enable = 1'b1;
        for (int burst = 0; burst < 6; burst++) begin
            bytes.delete();
            k         = $urandom_range(1, 3);
            miso_mode = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) begin
                bytes.push_back(DW'($urandom));
                push(bytes[i]);
            end
            wait_load("rand", ok);
            more = ok;
            for (int i = 0; i < k && more; i++) begin
                stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
                xfer("rand", bytes[i], 0, stall, more);
            end
            for (int i = 0; i < 3; i++) tick();
        end
        miso_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_rx_backpressure();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid_byte();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
